// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch stage: bus word, fetched-instruction
// record and the default reset PC.
package fetch_queue_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t instr;
      word_t pc;
      logic  fault;
   } fetch_t;

   localparam word_t RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/fetch_queue_if.sv
// Pipelined Wishbone read bus and the valid/ready pipeline link into decode.
interface wishbone;
   import fetch_queue_pkg::*;

   logic       stb;
   logic       stall;
   logic       ack;
   logic       err;
   logic       we;
   logic [3:0] sel;
   word_t      adr;
   word_t      dat_w;
   word_t      dat_r;

   modport master (output stb, we, sel, adr, dat_w, input stall, ack, err, dat_r);
   modport slave  (input stb, we, sel, adr, dat_w, output stall, ack, err, dat_r);
endinterface

interface pipeline import fetch_queue_pkg::*; #(parameter type T = fetch_t) ();
   logic valid;
   logic ready;
   T     data;

   modport dn (output valid, data, input ready);
   modport up (input valid, data, output ready);
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Full-capacity FIFO: pointers carry one extra wrap bit so all DEPTH slots are
// usable and full/empty fall out of the pointer difference.
module sync_fifo #(
   parameter int  DEPTH = 4,
   parameter type T     = logic
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   output T                           head,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   T            mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign count = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: sequential pipelined bus reads, credit-limited against a
// response FIFO with bypass to decode, exact redirect handling under stall.
module fetch_queue import fetch_queue_pkg::*; #(
   parameter int    DEPTH    = 4,
   parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    pc_flush,
   input  word_t   pc_new,
   wishbone.master bus,
   pipeline.dn     dn
);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

   word_t         pc, resp_pc, flush_pc, pc_tgt;
   logic [CW-1:0] outst, discard, occ, outst_next;
   logic [CW:0]   credit;
   logic          halted, flush_pending, stb_held;
   logic          accept, held_now, flush_now, flush_late;
   logic          resp, drop, fresh, push, pop;
   fetch_t        entry, fifo_head;

   assign pc_tgt     = pc_new & ~32'd3;
   assign credit     = {1'b0, occ} + {1'b0, outst};
   assign bus.adr    = pc;
   assign bus.we     = 1'b0;
   assign bus.sel    = '1;
   assign bus.dat_w  = '0;

   // A request stalled on the bus stays asserted regardless of halt or redirect.
   always_comb begin
      bus.stb     = !rst && (stb_held ||
                    (!halted && discard == '0 && credit < CREDIT_MAX && !pc_flush));
      accept      = bus.stb && !bus.stall;
      held_now    = bus.stb && bus.stall;
      flush_now   = pc_flush && !held_now;
      flush_late  = pc_flush && held_now;
      resp        = bus.ack || bus.err;
      drop        = resp && discard != '0;
      fresh       = resp && discard == '0;
      entry.instr = bus.err ? '0 : bus.dat_r;
      entry.pc    = resp_pc;
      entry.fault = bus.err;
      dn.valid    = !pc_flush && (occ != '0 || fresh);
      dn.data     = (occ != '0) ? fifo_head : entry;
      pop         = dn.valid && dn.ready && occ != '0;
      push        = fresh && !pc_flush && !(occ == '0 && dn.ready);
      outst_next  = outst + CW'(accept) - CW'(resp);
   end

   sync_fifo #(.DEPTH(DEPTH), .T(fetch_t)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (pc_flush),
      .push      (push),
      .push_data (entry),
      .pop       (pop),
      .head      (fifo_head),
      .count     (occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc            <= RESET_PC;
         resp_pc       <= RESET_PC;
         flush_pc      <= RESET_PC;
         outst         <= '0;
         discard       <= '0;
         halted        <= 1'b0;
         flush_pending <= 1'b0;
         stb_held      <= 1'b0;
      end else begin
         outst    <= outst_next;
         stb_held <= held_now;
         if (fresh)          resp_pc <= resp_pc + 32'd4;
         if (fresh && bus.err) halted <= 1'b1;
         if (pc_flush) begin
            resp_pc <= pc_tgt;
            halted  <= 1'b0;
            discard <= outst_next;
         end else begin
            // the held pre-redirect request is dropped once it is finally taken
            discard <= discard - CW'(drop) + CW'(accept && flush_pending);
         end
         if (flush_now) begin
            pc            <= pc_tgt;
            flush_pending <= 1'b0;
         end else if (flush_late) begin
            flush_pc      <= pc_tgt;
            flush_pending <= 1'b1;
         end else if (accept) begin
            pc            <= flush_pending ? flush_pc : pc + 32'd4;
            flush_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a bus model answers accepted reads, and a
// scoreboard of expected fetch records is built from accepted addresses.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int    DEPTH = 4;
   localparam word_t RPC   = 32'h8000_0000;
   localparam word_t NOERR = 32'hFFFF_FFFF;

   logic  clk = 1'b0;
   logic  rst;
   logic  pc_flush;
   word_t pc_new;

   wishbone bus_if ();
   pipeline #(.T(fetch_t)) dn_if ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk      (clk),
      .rst      (rst),
      .pc_flush (pc_flush),
      .pc_new   (pc_new),
      .bus      (bus_if),
      .dn       (dn_if)
   );

   always #5 clk = ~clk;

   int     n_tests = 0;
   int     n_fail  = 0;
   fetch_t exp_q[$];
   word_t  pend[$];
   word_t  exp_adr, flush_tgt, err_addr, first_pc;
   logic   drop_next, ack_en, got_first;
   logic   last_resp, last_valid, last_stb;
   int     n_acc, n_del, prior, acc_before;

   function automatic word_t mem_word(input word_t a);
      return (a ^ 32'hA5A5_F00F) + 32'd19;
   endfunction

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: present bus response, sample outputs mid-cycle, update model.
   task automatic step();
      logic   r_ack, r_err;
      fetch_t e;
      word_t  tmp;
      r_ack = 1'b0;
      r_err = 1'b0;
      if (!rst && ack_en && pend.size() > 0) begin
         if (pend[0] == err_addr) r_err = 1'b1;
         else                     r_ack = 1'b1;
      end
      bus_if.ack   = r_ack;
      bus_if.err   = r_err;
      bus_if.dat_r = (pend.size() > 0) ? (r_err ? 32'hDEAD_BEEF : mem_word(pend[0])) : 32'h0;
      #1;
      last_resp  = r_ack | r_err;
      last_valid = dn_if.valid;
      last_stb   = bus_if.stb;
      if (!rst) begin
         if (pc_flush) check("flush_valid", 65'(dn_if.valid), 65'(0));
         if (dn_if.valid && dn_if.ready) begin
            n_del++;
            check("sb_nonempty", 65'(exp_q.size() != 0), 65'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("dn_data", dn_if.data, e);
               if (!got_first) begin
                  first_pc  = dn_if.data.pc;
                  got_first = 1'b1;
               end
            end
         end
         if (last_resp) tmp = pend.pop_front();
         if (bus_if.stb && !bus_if.stall) begin
            n_acc++;
            check("adr", 65'(bus_if.adr), 65'(exp_adr));
            pend.push_back(bus_if.adr);
            if (pc_flush || drop_next) begin
               exp_adr   = drop_next ? flush_tgt : exp_adr + 32'd4;
               drop_next = 1'b0;
            end else begin
               e.instr = (exp_adr == err_addr) ? 32'h0 : mem_word(exp_adr);
               e.pc    = exp_adr;
               e.fault = (exp_adr == err_addr);
               exp_q.push_back(e);
               exp_adr = exp_adr + 32'd4;
            end
         end
         if (pc_flush) begin
            exp_q.delete();
            if (bus_if.stb && bus_if.stall) begin
               drop_next = 1'b1;
               flush_tgt = pc_new & ~32'd3;
            end else begin
               exp_adr = pc_new & ~32'd3;
            end
         end
      end else begin
         pend.delete();
         exp_q.delete();
         drop_next = 1'b0;
         exp_adr   = RPC;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      pc_flush     = 1'b0;
      pc_new       = 32'h0;
      bus_if.stall = 1'b0;
      dn_if.ready  = 1'b1;
      ack_en       = 1'b1;
      err_addr     = NOERR;
      step();
      check("stb_in_rst", 65'(last_stb), 65'(0));
      rst       = 1'b0;
      n_acc     = 0;
      n_del     = 0;
      got_first = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic flush_to(input word_t tgt);
      pc_flush = 1'b1;
      pc_new   = tgt;
      step();
      pc_flush = 1'b0;
   endtask

   initial begin
      bus_if.ack   = 1'b0;
      bus_if.err   = 1'b0;
      bus_if.dat_r = 32'h0;
      @(negedge clk);

      // streaming through bypass, one per cycle
      do_reset();
      step();
      check("stb_after_rst", 65'(last_stb), 65'(1));
      for (int i = 0; i < 11; i++) begin
         step();
         if (last_resp) check("bypass_valid", 65'(last_valid), 65'(1));
      end
      check("stream_count", 65'(n_del), 65'(11));

      // back-pressure: credit caps issue at DEPTH, then drain in order
      do_reset();
      dn_if.ready = 1'b0;
      run(10);
      check("credit_acc", 65'(n_acc), 65'(DEPTH));
      check("credit_stb", 65'(last_stb), 65'(0));
      dn_if.ready = 1'b1;
      run(12);
      check("drain_count", 65'(n_del >= DEPTH), 65'(1));
      check("issue_resume", 65'(n_acc > DEPTH), 65'(1));

      // redirect with three requests outstanding
      do_reset();
      ack_en = 1'b0;
      run(3);
      check("outst_acc", 65'(n_acc), 65'(3));
      flush_to(32'h8000_1000);
      ack_en = 1'b1;
      run(12);
      check("flush_got", 65'(got_first), 65'(1));
      check("flush_first_pc", 65'(first_pc), 65'(32'h8000_1000));

      // redirect while a request is held stalled
      do_reset();
      bus_if.stall = 1'b1;
      run(2);
      flush_to(32'h8000_2000);
      run(2);
      bus_if.stall = 1'b0;
      run(10);
      check("stall_got", 65'(got_first), 65'(1));
      check("stall_first_pc", 65'(first_pc), 65'(32'h8000_2000));

      // bus error halts issue until redirect
      do_reset();
      err_addr = 32'h8000_0008;
      run(8);
      check("err_del", 65'(n_del), 65'(4));
      check("halt_stb", 65'(last_stb), 65'(0));
      err_addr   = NOERR;
      acc_before = n_acc;
      flush_to(32'h8000_0101);
      run(6);
      check("halt_resume", 65'(n_acc > acc_before), 65'(1));

      // redirect coinciding with a bypassable ack
      do_reset();
      ack_en = 1'b0;
      run(2);
      prior     = pend.size();
      ack_en    = 1'b1;
      got_first = 1'b0;
      flush_to(32'h8000_3000);
      check("discard_cnt", 65'(dut.discard), 65'(prior - 1));
      run(8);
      check("coinc_got", 65'(got_first), 65'(1));
      check("coinc_first_pc", 65'(first_pc), 65'(32'h8000_3000));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
